stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control sequencer for the stopwatch datapath: turns start/stop/clear command pulses into a run/pause state machine and prescales the system clock into one-second ticks. Owns the seconds count (0–59) and drives the `enable` and `clear` inputs of the minutes counter (0–99), so both registers advance and clear on the same clock edge. Sits between the debounced button pulses and the counter/display datapath.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second tick; must be ≥ 2; prescaler width is `$clog2(TICKS_PER_SEC)`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle command pulse: run.
- `stop`  in  1  single-cycle command pulse: pause.
- `clear`  in  1  single-cycle command pulse: zero the stopwatch and return to idle.
- `minutes`  in  7  current minutes-counter value, fed back for the saturation check.
- `seconds`  out  6  seconds count, 0–59.
- `min_enable`  out  1  one-cycle increment strobe to the minutes counter's `enable`.
- `min_clear`  out  1  clear strobe to the minutes counter's `clear`.
- `state`  out  2  FSM state: IDLE=0, RUNNING=1, PAUSED=2, DONE=3.
- `running`  out  1  high when `state`==RUNNING.
- `done`  out  1  high when `state`==DONE.

## Operation
- **Reset.** `state`=IDLE, prescaler=0, `seconds`=0. All outputs are 0 during and after reset until a command arrives.
- **Command priority.** `clear` > `stop` > `start` when several are asserted in the same cycle.
- **Clear.** Accepted in any state.
  - Next edge: `state`→IDLE, prescaler→0, `seconds`→0.
  - `min_clear` = `clear` combinationally, so the minutes counter clears on the same edge.
  - `min_enable` is forced 0 in that cycle.
- **Start.** Accepted in IDLE or PAUSED; `state`→RUNNING. Ignored in RUNNING and DONE.
- **Stop.** Accepted in RUNNING only; `state`→PAUSED. Ignored elsewhere.
- **Prescaler.**
  - In RUNNING, increments every cycle.
  - At `TICKS_PER_SEC`-1 it wraps to 0 and raises an internal `sec_tick` for that cycle.
  - In PAUSED it holds its value, so resume continues mid-second.
  - In IDLE and DONE it is held at 0.
- **Seconds.**
  - On `sec_tick`: if `seconds`==59, `seconds`→0; otherwise `seconds`+1.
  - `min_enable` = RUNNING & `sec_tick` & (`seconds`==59) & no `clear`. It is combinational from registered state, so minutes and seconds update on the same edge.
- **Stop on the tick cycle.** If `stop` is asserted in the same cycle as `sec_tick`, the tick is discarded: the prescaler holds at `TICKS_PER_SEC`-1, `seconds` is unchanged and `min_enable`=0. The tick then fires on the first RUNNING cycle after resume.
- **Rollover at 99:59.** Handling depends on the saturation feature (see Configuration).

## Timing
- Command pulse at edge N → `state` changes at edge N+1. `running`/`done` are decoded from `state`, so they change together with it.
- First `sec_tick` occurs `TICKS_PER_SEC` cycles after entering RUNNING from IDLE.
- `seconds` updates at the edge ending the `sec_tick` cycle.
- `min_enable` and `min_clear` are valid in the same cycle as their cause (zero latency) and are exactly one cycle wide for single-cycle inputs.
- Asserting `rst_n` low mid-count zeroes all state immediately, independent of `clk`.

## Configuration
- **`STOPWATCH_SATURATE_EN` defined:**
  - A `sec_tick` with `minutes`==99 and `seconds`==59 moves `state`→DONE.
  - `seconds` stays 59, `min_enable` stays 0, and the prescaler is cleared.
  - DONE holds 99:59 and exits only on `clear`.
- **`STOPWATCH_SATURATE_EN` not defined:**
  - DONE is unreachable.
  - At 99:59 the tick asserts `min_enable`; the minutes counter wraps 99→0 and `seconds`→0 (display shows 00:00).
  - `state` remains RUNNING.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- Reset then start: `start` pulse → `running`=1 next cycle. First `seconds` increment (0→1) occurs 4 cycles later; after 240 RUNNING cycles, `seconds`=0 with exactly one `min_enable` pulse, on the 59→0 edge.
- Pause and resume: `stop` 2 cycles into a second → `seconds` frozen for 50 cycles. `start` → next increment occurs 2 cycles later.
- Simultaneous commands:
  - `start`+`stop` while RUNNING → PAUSED.
  - `clear`+`start` while PAUSED at 00:37 → IDLE, `seconds`=0, `min_clear`=1 for one cycle, `min_enable`=0.
- Tick collision: `stop` exactly on a `sec_tick` cycle → `seconds` unchanged and no `min_enable`. Tick fires on the first cycle after `start`.
- Rollover with `minutes` driven 99 and `seconds`=59:
  - With macro → DONE, display holds 99:59, `start` ignored, `clear` → IDLE.
  - Without macro → `min_enable`=1, `seconds`=0, still RUNNING.
- Async reset asserted mid-second in RUNNING → all outputs 0 immediately. After release, stays IDLE with no ticks until `start`.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: run/pause FSM, one-second prescaler, seconds count
// (0-59) and the enable/clear strobes for the external minutes counter (0-99).
// Optional build macro: STOPWATCH_SATURATE_EN -- stop in DONE at 99:59 instead of
// wrapping to 00:00.
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       min_enable,
  output logic       min_clear,
  output logic [1:0] state,
  output logic       running,
  output logic       done
);

  localparam int unsigned PresW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d;
  logic             sec_tick;
  logic             sec_wrap;
  logic             at_max;
  logic             tick_go;

  assign sec_tick = (state_q == StRun) && (presc_q == PresLast);
  assign sec_wrap = (sec_q == 6'd59);
  // A tick only takes effect when no clear or stop discards it.
  assign tick_go  = sec_tick && !stop && !clear;

`ifdef STOPWATCH_SATURATE_EN
  assign at_max = (minutes == 7'd99) && sec_wrap;
`else
  logic unused_minutes;
  assign unused_minutes = ^minutes;
  assign at_max         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; clear beats stop beats start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StRun;
        StRun: begin
          if (stop) begin
            state_d = StPause;
          end else if (sec_tick && at_max) begin
            state_d = StDone;
          end
        end
        StPause: if (!stop && start) state_d = StRun;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler and seconds registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  // Prescaler/seconds next values; a stop on the tick cycle parks the prescaler at its
  // last count so the tick fires on the first cycle after resume.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (clear) begin
      presc_d = '0;
      sec_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: presc_d = '0;
        StPause:        presc_d = presc_q;
        StRun: begin
          if (sec_tick) begin
            if (!stop) begin
              presc_d = '0;
              if (!at_max) begin
                sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
              end
            end
          end else begin
            presc_d = presc_q + PresW'(1);
          end
        end
        default: presc_d = '0;
      endcase
    end
  end

  // Outputs: strobes are combinational so minutes and seconds move on the same edge.
  always_comb begin
    seconds    = sec_q;
    state      = state_q;
    running    = (state_q == StRun);
    done       = (state_q == StDone);
    min_clear  = clear;
    min_enable = tick_go && sec_wrap && !at_max;
  end

endmodule
